// File: rtl/sigmoid_lane_serializer_if.sv
// Bus bundle between the 2-lane sigmoid stage, the serializer and the serial
// consumer.
//   valid_in, y0_in, y1_in : result pair from the sigmoid stage
//   in_afull, overflow     : feeder-side status flags
//   m_data, m_valid,
//   m_ready, m_last        : serial output stream
// Handshake: a sample moves on m_data exactly in cycles where m_valid and
// m_ready are both high at the rising edge. While m_valid is high and m_ready
// is low, m_data and m_last hold. valid_in has no back-pressure; the feeder
// throttles on in_afull, and pairs arriving while full are dropped.
// Modports: slave = serializer side, master = feeder/consumer side.
interface sigmoid_lane_serializer_if #(
  parameter int DATA_W = 16
);
  logic              valid_in;
  logic [DATA_W-1:0] y0_in;
  logic [DATA_W-1:0] y1_in;
  logic              in_afull;
  logic              overflow;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport slave (
    input  valid_in, y0_in, y1_in, m_ready,
    output in_afull, overflow, m_data, m_valid, m_last
  );

  modport master (
    output valid_in, y0_in, y1_in, m_ready,
    input  in_afull, overflow, m_data, m_valid, m_last
  );
endinterface

// File: rtl/sigmoid_lane_serializer.sv
// Pair-to-serial converter for the 2-lane sigmoid pipeline.
// Each valid result pair {y1,y0} is stored in a pair FIFO. Samples leave one
// per transfer, lane 0 then lane 1, and the head pair is popped after its
// lane 1 sample is taken. m_last marks every FRAME_LEN-th sample. in_afull
// warns the feeder early enough to cover pairs still in flight. overflow is
// sticky and records a dropped pair.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous flush of FIFO, lane select, frame count, overflow
//   bus        : sigmoid_lane_serializer_if.slave (input pair, status, stream)
module sigmoid_lane_serializer #(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 3,
  parameter int FRAME_LEN    = 40
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  sigmoid_lane_serializer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] AFULL_C = CW'(DEPTH - AFULL_MARGIN);
  localparam logic [FW-1:0] FLAST_C = FW'(FRAME_LEN - 1);

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]       wr_ptr, rd_ptr, count, count_nxt;
  logic                sel;
  logic [FW-1:0]       fcnt;
  logic                overflow_q, afull_q;
  logic                empty, full, xfer, pop, push, drop;
  logic [2*DATA_W-1:0] head;

  always_comb begin
    // The extra pointer MSB tells full (MSBs differ) from empty (all equal).
    empty     = (wr_ptr == rd_ptr);
    full      = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    xfer      = !empty && bus.m_ready;
    pop       = xfer && sel;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push      = bus.valid_in && (!full || pop);
    drop      = bus.valid_in && !push;
    count_nxt = clear ? '0 : (count + CW'(push) - CW'(pop));
    head      = mem[rd_ptr[AW-1:0]];
  end

  // Sample storage has no reset; nothing is visible while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr[AW-1:0]] <= {bus.y1_in, bus.y0_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sel        <= 1'b0;
      fcnt       <= '0;
      overflow_q <= 1'b0;
      afull_q    <= 1'b0;
    end else begin
      count   <= count_nxt;
      afull_q <= (count_nxt >= AFULL_C);
      if (clear) begin
        // Clear wins over any push/pop this cycle; the pair is simply lost.
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        sel        <= 1'b0;
        fcnt       <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (drop) overflow_q <= 1'b1;
        if (xfer) begin
          sel  <= !sel;
          fcnt <= (fcnt == FLAST_C) ? '0 : fcnt + 1'b1;
        end
      end
    end
  end

  assign bus.m_valid  = !empty;
  assign bus.m_data   = empty ? '0 : (sel ? head[2*DATA_W-1:DATA_W] : head[DATA_W-1:0]);
  assign bus.m_last   = !empty && (fcnt == FLAST_C);
  assign bus.in_afull = afull_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_sigmoid_lane_serializer.sv
// Bench for sigmoid_lane_serializer. Two instances share all inputs: one with
// FRAME_LEN=40 and one with FRAME_LEN=5. The reference model is a queue of
// pairs plus a lane flag, two frame counters and the flag bits.
module tb_sigmoid_lane_serializer;
  localparam int W      = 16;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 3;
  localparam int FL_A   = 40;
  localparam int FL_B   = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  always #5 clk = ~clk;

  sigmoid_lane_serializer_if #(.DATA_W(W)) ifa ();
  sigmoid_lane_serializer_if #(.DATA_W(W)) ifb ();
  assign ifb.valid_in = ifa.valid_in;
  assign ifb.y0_in    = ifa.y0_in;
  assign ifb.y1_in    = ifa.y1_in;
  assign ifb.m_ready  = ifa.m_ready;

  sigmoid_lane_serializer #(.DATA_W(W), .DEPTH(DEPTH), .AFULL_MARGIN(MARGIN), .FRAME_LEN(FL_A))
    dut_a (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifa));
  sigmoid_lane_serializer #(.DATA_W(W), .DEPTH(DEPTH), .AFULL_MARGIN(MARGIN), .FRAME_LEN(FL_B))
    dut_b (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifb));

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [2*W-1:0] exp_q[$];
  logic           m_sel;
  int             fcnt_a, fcnt_b;
  logic           m_ovf, m_afull;

  task automatic model_reset();
    exp_q.delete();
    m_sel  = 1'b0;
    fcnt_a = 0;
    fcnt_b = 0;
    m_ovf  = 1'b0;
    m_afull = 1'b0;
  endtask

  // {m_valid, m_last, in_afull, overflow, m_data}
  function automatic logic [W+3:0] exp_vec(bit use_b);
    logic [2*W-1:0] hd;
    logic           v, l;
    logic [W-1:0]   d;
    v = (exp_q.size() != 0);
    d = '0;
    if (v) begin
      hd = exp_q[0];
      d  = m_sel ? hd[2*W-1:W] : hd[W-1:0];
    end
    l = v && (use_b ? (fcnt_b == FL_B - 1) : (fcnt_a == FL_A - 1));
    return {v, l, m_afull, m_ovf, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(bit v, logic [W-1:0] a, logic [W-1:0] b, bit rdy);
    ifa.valid_in = v;
    ifa.y0_in    = a;
    ifa.y1_in    = b;
    ifa.m_ready  = rdy;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT sees.
  task automatic cycle();
    bit xfer, pop, push;
    xfer = (exp_q.size() != 0) && ifa.m_ready;
    pop  = xfer && m_sel;
    push = ifa.valid_in && ((exp_q.size() < DEPTH) || pop);
    @(posedge clk);
    if (clear) begin
      model_reset();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back({ifa.y1_in, ifa.y0_in});
      if (ifa.valid_in && !push) m_ovf = 1'b1;
      if (xfer) begin
        m_sel  = !m_sel;
        fcnt_a = (fcnt_a + 1) % FL_A;
        fcnt_b = (fcnt_b + 1) % FL_B;
      end
      m_afull = (exp_q.size() >= DEPTH - MARGIN);
    end
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ifa.m_valid, ifa.m_last, ifa.in_afull, ifa.overflow, ifa.m_data} !== '0) begin
      bad++;
      $display("FAIL reset_a got=%h exp=0", {ifa.m_valid, ifa.m_last, ifa.in_afull, ifa.overflow, ifa.m_data});
    end
    total++;
    if ({ifb.m_valid, ifb.m_last, ifb.in_afull, ifb.overflow, ifb.m_data} !== '0) begin
      bad++;
      $display("FAIL reset_b got=%h exp=0", {ifb.m_valid, ifb.m_last, ifb.in_afull, ifb.overflow, ifb.m_data});
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_pair();
    drive(1, 16'h0400, 16'h07FF, 1);
    cycle();
    drive(0, '0, '0, 1);
    total++;
    if ({ifa.m_valid, ifa.m_data} !== {1'b1, 16'h0400}) begin
      bad++; $display("FAIL single_lane0 got=%h exp=%h", {ifa.m_valid, ifa.m_data}, {1'b1, 16'h0400});
    end
    cycle();
    total++;
    if ({ifa.m_valid, ifa.m_data} !== {1'b1, 16'h07FF}) begin
      bad++; $display("FAIL single_lane1 got=%h exp=%h", {ifa.m_valid, ifa.m_data}, {1'b1, 16'h07FF});
    end
    cycle();
    total++;
    if (ifa.m_valid !== 1'b0) begin
      bad++; $display("FAIL single_empty got=%b exp=0", ifa.m_valid);
    end
  endtask

  task automatic test_backpressure();
    drive(1, 16'hFC00, 16'h0001, 0);
    cycle();
    drive(0, '0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({ifa.m_valid, ifa.m_data} !== {1'b1, 16'hFC00}) begin
        bad++; $display("FAIL bp_hold%0d got=%h exp=%h", i, {ifa.m_valid, ifa.m_data}, {1'b1, 16'hFC00});
      end
      cycle();
    end
    drive(0, '0, '0, 1);
    total++;
    if ({ifa.m_valid, ifa.m_data} !== {1'b1, 16'hFC00}) begin
      bad++; $display("FAIL bp_lane0 got=%h exp=%h", {ifa.m_valid, ifa.m_data}, {1'b1, 16'hFC00});
    end
    cycle();
    total++;
    if ({ifa.m_valid, ifa.m_data} !== {1'b1, 16'h0001}) begin
      bad++; $display("FAIL bp_lane1 got=%h exp=%h", {ifa.m_valid, ifa.m_data}, {1'b1, 16'h0001});
    end
    cycle();
    total++;
    if (ifa.m_valid !== 1'b0) begin
      bad++; $display("FAIL bp_empty got=%b exp=0", ifa.m_valid);
    end
  endtask

  // 21 pairs carrying sample indices 0..41, one pair every other cycle.
  task automatic test_frame();
    int p = 0;
    int k = 0;
    do_clear();
    for (int c = 0; c < 120 && k < 42; c++) begin
      if ((c % 2 == 0) && p < 21) begin
        drive(1, W'(2 * p), W'(2 * p + 1), 1);
        p++;
      end else begin
        drive(0, '0, '0, 1);
      end
      if (ifa.m_valid === 1'b1) begin
        total++;
        if ({ifa.m_data, ifa.m_last, ifb.m_last} !== {W'(k), k == 39, (k % 5) == 4}) begin
          bad++;
          $display("FAIL frame_s%0d got data=%h last_a=%b last_b=%b exp data=%h last_a=%b last_b=%b",
                   k, ifa.m_data, ifa.m_last, ifb.m_last, W'(k), k == 39, (k % 5) == 4);
        end
        k++;
      end
      cycle();
    end
    total++;
    if (k != 42) begin
      bad++; $display("FAIL frame_count got=%0d exp=42", k);
    end
  endtask

  task automatic test_full_overflow();
    do_clear();
    for (int n = 1; n <= 8; n++) begin
      drive(1, W'(16'h1000 + n), W'(16'h2000 + n), 0);
      cycle();
      total++;
      if ({ifa.in_afull, ifa.overflow} !== {n >= 5, 1'b0}) begin
        bad++; $display("FAIL fill_afull%0d got=%b%b exp=%b0", n, ifa.in_afull, ifa.overflow, n >= 5);
      end
    end
    drive(1, 16'h1009, 16'h2009, 0);
    cycle();
    total++;
    if (ifa.overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_set got=%b exp=1", ifa.overflow);
    end
    drive(0, '0, '0, 1);
    for (int i = 1; i <= 8; i++) begin
      for (int l = 0; l < 2; l++) begin
        total++;
        if ({ifa.m_valid, ifa.m_data} !== {1'b1, (l == 1) ? W'(16'h2000 + i) : W'(16'h1000 + i)}) begin
          bad++; $display("FAIL drain_p%0d_l%0d got=%h exp=%h", i, l, {ifa.m_valid, ifa.m_data},
                          {1'b1, (l == 1) ? W'(16'h2000 + i) : W'(16'h1000 + i)});
        end
        cycle();
      end
    end
    total++;
    if ({ifa.m_valid, ifa.overflow} !== 2'b01) begin
      bad++; $display("FAIL drain_end got=%b exp=01", {ifa.m_valid, ifa.overflow});
    end
  endtask

  task automatic test_full_pop();
    logic [W-1:0] want;
    do_clear();
    for (int n = 1; n <= 8; n++) begin
      drive(1, W'(16'h3000 + n), W'(16'h4000 + n), 0);
      cycle();
    end
    drive(0, '0, '0, 1);
    cycle();
    drive(1, 16'h5555, 16'h6666, 1);
    cycle();
    total++;
    if ({ifa.overflow, ifa.in_afull} !== 2'b01) begin
      bad++; $display("FAIL fullpop_flags got=%b exp=01", {ifa.overflow, ifa.in_afull});
    end
    drive(0, '0, '0, 1);
    for (int s = 0; s < 16; s++) begin
      if (s < 14) want = (s % 2 == 1) ? W'(16'h4002 + s / 2) : W'(16'h3002 + s / 2);
      else        want = (s == 15) ? 16'h6666 : 16'h5555;
      total++;
      if ({ifa.m_valid, ifa.m_data} !== {1'b1, want}) begin
        bad++; $display("FAIL fullpop_s%0d got=%h exp=%h", s, {ifa.m_valid, ifa.m_data}, {1'b1, want});
      end
      cycle();
    end
    total++;
    if (ifa.m_valid !== 1'b0) begin
      bad++; $display("FAIL fullpop_empty got=%b exp=0", ifa.m_valid);
    end
  endtask

  task automatic test_clear();
    do_clear();
    for (int n = 0; n < 9; n++) begin
      drive(1, W'(n), W'(n + 100), 0);
      cycle();
    end
    drive(0, '0, '0, 1);
    repeat (10) cycle();
    total++;
    if ({ifa.m_valid, ifa.overflow} !== 2'b11) begin
      bad++; $display("FAIL preclear got=%b exp=11", {ifa.m_valid, ifa.overflow});
    end
    clear = 1'b1;
    drive(1, 16'h7777, 16'h7777, 0);
    cycle();
    clear = 1'b0;
    drive(0, '0, '0, 0);
    total++;
    if ({ifa.m_valid, ifa.overflow, ifa.in_afull, ifb.m_valid, ifb.overflow} !== 5'b0) begin
      bad++; $display("FAIL postclear got=%b exp=00000",
                      {ifa.m_valid, ifa.overflow, ifa.in_afull, ifb.m_valid, ifb.overflow});
    end
    for (int n = 0; n < 3; n++) begin
      drive(1, W'(16'h0A00 + n), W'(16'h0B00 + n), 0);
      cycle();
    end
    drive(0, '0, '0, 1);
    for (int s = 0; s < 6; s++) begin
      total++;
      if ({ifa.m_data, ifa.m_last, ifb.m_last} !==
          {(s % 2 == 1) ? W'(16'h0B00 + s / 2) : W'(16'h0A00 + s / 2), 1'b0, s == 4}) begin
        bad++; $display("FAIL clear_frame_s%0d got data=%h last_a=%b last_b=%b exp last_b=%b",
                        s, ifa.m_data, ifa.m_last, ifb.m_last, s == 4);
      end
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 4; n++) begin
      drive(1, W'($urandom), W'($urandom), 0);
      cycle();
    end
    drive(0, '0, '0, 1);
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ifa.m_valid, ifa.m_last, ifa.in_afull, ifa.overflow, ifa.m_data,
         ifb.m_valid, ifb.m_last, ifb.in_afull, ifb.overflow, ifb.m_data} !== '0) begin
      bad++; $display("FAIL async_reset got=%h_%h exp=0",
                      {ifa.m_valid, ifa.m_last, ifa.in_afull, ifa.overflow, ifa.m_data},
                      {ifb.m_valid, ifb.m_last, ifb.in_afull, ifb.overflow, ifb.m_data});
    end
    model_reset();
    drive(0, '0, '0, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int rdy_pct;
    for (int c = 0; c < 800; c++) begin
      rdy_pct = (c < 400) ? 35 : 85;
      drive($urandom_range(0, 2) != 0, W'($urandom), W'($urandom), $urandom_range(0, 99) < rdy_pct);
      clear = ($urandom_range(0, 59) == 0);
      total++;
      if ({ifa.m_valid, ifa.m_last, ifa.in_afull, ifa.overflow, ifa.m_data} !== exp_vec(0)) begin
        bad++; $display("FAIL rand_a c=%0d got=%h exp=%h", c,
                        {ifa.m_valid, ifa.m_last, ifa.in_afull, ifa.overflow, ifa.m_data}, exp_vec(0));
      end
      total++;
      if ({ifb.m_valid, ifb.m_last, ifb.in_afull, ifb.overflow, ifb.m_data} !== exp_vec(1)) begin
        bad++; $display("FAIL rand_b c=%0d got=%h exp=%h", c,
                        {ifb.m_valid, ifb.m_last, ifb.in_afull, ifb.overflow, ifb.m_data}, exp_vec(1));
      end
      cycle();
    end
    clear = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    drive(0, '0, '0, 0);
    model_reset();
    test_reset();
    test_single_pair();
    test_backpressure();
    test_frame();
    test_full_overflow();
    test_full_pop();
    test_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
